c64_bus_arbiter: RTL and testbench
==================================

Name: c64_bus_arbiter

Overview:
- Shares the single 64K system memory bus between the 6502 core and the VIC-II video fetch engine.
- Splits each system cycle into two clk phases: phase 0 is the VIC slot and phase 1 is the CPU slot.
- Implements C64-style cycle stealing: the VIC raises a DMA request, and the arbiter asserts BA and stalls CPU reads for BA_LEAD system cycles before handing the VIC both phases.
- Sits between the CPU/VIC address, data and write-enable signals and the RAM/ROM/IO decode.

Parameters:
- BA_LEAD, 3: system cycles between BA falling and VIC taking both phases.
- AW, 16: address width.

Ports:
- clk, input, 1: system clock. One system cycle is 2 clk.
- reset, input, 1: asynchronous, active-low reset.
- cpu_ab, input, AW: CPU address.
- cpu_do, input, 8: CPU write data.
- cpu_we, input, 1: CPU write enable (1 = write).
- cpu_di, output, 8: registered read data to the CPU.
- cpu_rdy, output, 1: 1 = CPU read may complete; 0 = CPU must hold its read.
- vic_ab, input, AW: VIC fetch address.
- vic_req, input, 1: VIC requests a full-bus steal (badline/sprite DMA).
- vic_di, output, 8: registered read data to the VIC.
- vic_grant, output, 1: VIC owns both phases.
- ph, output, 1: current phase (0 = VIC slot, 1 = CPU slot).
- ba, output, 1: bus available, active-low warning.
- aec, output, 1: 1 = CPU drives mem_* this clk.
- mem_ab, output, AW: memory address.
- mem_do, output, 8: memory write data.
- mem_we, output, 1: memory write strobe.
- mem_di, input, 8: memory read data, valid in the same clk as mem_ab.

Behaviour:
- Reset (reset=0, async): ph=0, state=CPU_OWN, lead counter=0, ba=1, cpu_rdy=1, vic_grant=0, cpu_di=0, vic_di=0. mem_we=0 while reset is asserted.
- ph toggles every clk after reset releases. The first clk after release is ph=0.
- A system-cycle boundary is a rising edge with ph=1. All state transitions happen only on boundaries.
- States:
  - CPU_OWN: ba=1, cpu_rdy=1. ph=0 carries VIC phase-0 fetches; ph=1 carries the CPU.
  - BA_WAIT: ba=0, cpu_rdy=0. ph=0 carries the VIC. In ph=1, a CPU write (cpu_we=1) is still performed; a CPU read is suppressed (aec=0, mem_we=0, cpu_di holds).
  - VIC_OWN: ba=0, cpu_rdy=0, vic_grant=1. Both phases carry vic_ab, aec=0, mem_we=0.
- Transitions:
  - CPU_OWN to BA_WAIT when vic_req=1 at a boundary; load counter=BA_LEAD-1.
  - BA_WAIT: decrement the counter each boundary. At a boundary with counter=0, go to VIC_OWN.
  - BA_WAIT to CPU_OWN at a boundary if vic_req=0 (abort). This takes priority over expiry.
  - VIC_OWN stays while vic_req=1. It returns to CPU_OWN at the first boundary with vic_req=0; ba=1 and cpu_rdy=1 from that edge.
- Bus mux (combinational from registered state/ph plus inputs):
  - aec = ph & (CPU_OWN | (BA_WAIT & cpu_we)).
  - mem_ab = aec ? cpu_ab : vic_ab.
  - mem_do = cpu_do.
  - mem_we = aec & cpu_we.
- Read capture:
  - At the rising edge ending a clk where aec=1 and cpu_we=0, cpu_di <= mem_di.
  - At the rising edge ending a clk where aec=0 and (ph=0 or VIC_OWN), vic_di <= mem_di.
  - Latency is 1 clk after the address phase; both registers otherwise hold.
- Simultaneous events: a vic_req change mid-cycle (at a ph=0 edge) is ignored until the next boundary.
- Reset mid-steal returns directly to CPU_OWN with reset values.
- The counter is sized to hold BA_LEAD-1 and never wraps.

Test Plan:
1. Reset release, vic_req=0, cpu_ab=16'h1234, cpu_we=0, mem_di=8'hA5 -> ph alternates 0,1,...; mem_ab=16'h1234 in every ph=1 clk; cpu_di=8'hA5 one clk later; ba=1; cpu_rdy=1 throughout.
2. Steady state, vic_req=1 at a boundary, BA_LEAD=3 -> ba=0 and cpu_rdy=0 from that edge; vic_grant=1 exactly 3 system cycles (6 clk) later; mem_ab=vic_ab in both phases afterward.
3. During BA_WAIT, CPU write cpu_ab=16'hD020, cpu_do=8'h0E -> mem_we=1 with mem_ab=16'hD020 in ph=1. Same test with cpu_we=0 -> mem_we=0 and cpu_di unchanged.
4. vic_req pulsed 1 for one system cycle, then 0 -> BA_WAIT for 1 system cycle; return to CPU_OWN with ba=1; vic_grant never asserted.
5. VIC_OWN for 40 system cycles, then vic_req=0 -> CPU_OWN at the next boundary; the first CPU read afterward returns mem_di correctly.
6. reset pulsed low mid-VIC_OWN -> outputs go immediately to reset values (ba=1, vic_grant=0, mem_we=0); ph restarts at 0 after release.

Source files
------------

// File: rtl/c64_bus_arbiter.sv
// Shares the 64K memory bus between the 6502 and the VIC-II: phase 0 is the VIC slot,
// phase 1 is the CPU slot, and a VIC DMA request steals both phases after a BA warning.
module c64_bus_arbiter #(
    parameter int BA_LEAD = 3,
    parameter int AW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_ab,
    input  logic [7:0]    cpu_do,
    input  logic          cpu_we,
    output logic [7:0]    cpu_di,
    output logic          cpu_rdy,
    input  logic [AW-1:0] vic_ab,
    input  logic          vic_req,
    output logic [7:0]    vic_di,
    output logic          vic_grant,
    output logic          ph,
    output logic          ba,
    output logic          aec,
    output logic [AW-1:0] mem_ab,
    output logic [7:0]    mem_do,
    output logic          mem_we,
    input  logic [7:0]    mem_di
);

    localparam int              CNT_W    = (BA_LEAD > 1) ? $clog2(BA_LEAD) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BA_LEAD - 1);

    typedef enum logic [1:0] {
        CPU_OWN,
        BA_WAIT,
        VIC_OWN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph    <= 1'b0;
            state <= CPU_OWN;
            cnt   <= '0;
        end else begin
            ph    <= ~ph;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The edge that ends a ph=1 clk is the only place the steal sequence may advance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ph) begin
            case (state)
                CPU_OWN: begin
                    if (vic_req) begin
                        state_nxt = BA_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
                BA_WAIT: begin
                    if (!vic_req) begin
                        state_nxt = CPU_OWN;
                        cnt_nxt   = '0;
                    end else if (cnt == '0) begin
                        state_nxt = VIC_OWN;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                VIC_OWN: begin
                    if (!vic_req) begin
                        state_nxt = CPU_OWN;
                    end
                end
                default: begin
                    state_nxt = CPU_OWN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign ba        = (state == CPU_OWN);
    assign cpu_rdy   = (state == CPU_OWN);
    assign vic_grant = (state == VIC_OWN);

    // During the BA warning the CPU may still finish writes; only its reads are held off.
    assign aec    = ph & ((state == CPU_OWN) | ((state == BA_WAIT) & cpu_we));
    assign mem_ab = aec ? cpu_ab : vic_ab;
    assign mem_do = cpu_do;
    assign mem_we = aec & cpu_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_di <= 8'h00;
            vic_di <= 8'h00;
        end else begin
            if (aec && !cpu_we) begin
                cpu_di <= mem_di;
            end
            if (!aec && (!ph || (state == VIC_OWN))) begin
                vic_di <= mem_di;
            end
        end
    end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Randomised scoreboard bench for c64_bus_arbiter: stimulus pushes expected per-clk bus
// behaviour from a steal-age reference model, a negedge monitor pops and compares.
module tb_c64_bus_arbiter;

    localparam int BA_LEAD = 3;
    localparam int AW      = 16;

    logic          clk;
    logic          reset;
    logic [AW-1:0] cpu_ab;
    logic [7:0]    cpu_do;
    logic          cpu_we;
    logic [7:0]    cpu_di;
    logic          cpu_rdy;
    logic [AW-1:0] vic_ab;
    logic          vic_req;
    logic [7:0]    vic_di;
    logic          vic_grant;
    logic          ph;
    logic          ba;
    logic          aec;
    logic [AW-1:0] mem_ab;
    logic [7:0]    mem_do;
    logic          mem_we;
    logic [7:0]    mem_di;

    c64_bus_arbiter #(.BA_LEAD(BA_LEAD), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
        .vic_ab(vic_ab), .vic_req(vic_req), .vic_di(vic_di), .vic_grant(vic_grant),
        .ph(ph), .ba(ba), .aec(aec),
        .mem_ab(mem_ab), .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          ph;
        logic          ba;
        logic          rdy;
        logic          grant;
        logic          aec;
        logic          we;
        logic [AW-1:0] ab;
        logic [7:0]    mdo;
        logic [7:0]    cdi;
        logic [7:0]    vdi;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: age = -1 means no steal; otherwise system cycles since the request
    // was seen. The VIC owns the bus once BA_LEAD cycles of warning have elapsed.
    logic       m_ph;
    int         m_age;
    logic [7:0] m_cdi;
    logic [7:0] m_vdi;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ph",        16'(ph),        16'(e.ph));
            chk("ba",        16'(ba),        16'(e.ba));
            chk("cpu_rdy",   16'(cpu_rdy),   16'(e.rdy));
            chk("vic_grant", 16'(vic_grant), 16'(e.grant));
            chk("aec",       16'(aec),       16'(e.aec));
            chk("mem_we",    16'(mem_we),    16'(e.we));
            chk("mem_ab",    mem_ab,         e.ab);
            chk("mem_do",    16'(mem_do),    16'(e.mdo));
            chk("cpu_di",    16'(cpu_di),    16'(e.cdi));
            chk("vic_di",    16'(vic_di),    16'(e.vdi));
        end
    end

    task automatic step(input logic rq, input logic we, input logic [15:0] ab,
                        input logic [7:0] dout, input logic [15:0] vab,
                        input logic [7:0] mdi, input logic rn);
        exp_t e;
        logic waiting;
        logic owned;
        logic cpu_side;
        @(posedge clk);
        #1;
        vic_req = rq;
        cpu_we  = we;
        cpu_ab  = ab;
        cpu_do  = dout;
        vic_ab  = vab;
        mem_di  = mdi;
        reset   = rn;
        if (!rn) begin
            m_ph  = 1'b0;
            m_age = -1;
            m_cdi = 8'h00;
            m_vdi = 8'h00;
        end
        waiting  = (m_age >= 0) && (m_age < BA_LEAD);
        owned    = (m_age >= BA_LEAD);
        cpu_side = m_ph && ((m_age < 0) || (waiting && we));
        e.ph    = m_ph;
        e.ba    = (m_age < 0);
        e.rdy   = (m_age < 0);
        e.grant = owned;
        e.aec   = cpu_side;
        e.we    = cpu_side && we;
        e.ab    = cpu_side ? ab : vab;
        e.mdo   = dout;
        e.cdi   = m_cdi;
        e.vdi   = m_vdi;
        q.push_back(e);
        if (rn) begin
            if (cpu_side && !we) m_cdi = mdi;
            if (!cpu_side && (!m_ph || owned)) m_vdi = mdi;
            if (m_ph) begin
                if (m_age < 0) begin
                    if (rq) m_age = 0;
                end else if (!rq) begin
                    m_age = -1;
                end else if (m_age < BA_LEAD) begin
                    m_age = m_age + 1;
                end
            end
            m_ph = ~m_ph;
        end
    endtask

    initial begin
        logic rq;
        reset   = 1'b0;
        vic_req = 1'b0;
        cpu_we  = 1'b0;
        cpu_ab  = 16'h0000;
        cpu_do  = 8'h00;
        vic_ab  = 16'h0000;
        mem_di  = 8'h00;
        m_ph    = 1'b0;
        m_age   = -1;
        m_cdi   = 8'h00;
        m_vdi   = 8'h00;

        repeat (2) step(1'b0, 1'b0, 16'h1234, 8'h00, 16'h0400, 8'h5A, 1'b0);
        // Plain CPU reads after release.
        repeat (8) step(1'b0, 1'b0, 16'h1234, 8'h00, 16'h0400, 8'hA5, 1'b1);
        // Steal request with reads and D020 writes during the BA warning.
        for (int i = 0; i < 16; i++)
            step(1'b1, (i % 4) >= 2, ((i % 4) >= 2) ? 16'hD020 : 16'h1234, 8'h0E,
                 16'h0400 + 16'(i), 8'(i * 7 + 3), 1'b1);
        // Long VIC ownership, then release and CPU reads.
        for (int i = 0; i < 80; i++)
            step(1'b1, 1'b0, 16'h2000, 8'h11, 16'h0800 + 16'(i), 8'($urandom), 1'b1);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 16'hC000 + 16'(i), 8'h22, 16'h0900, 8'($urandom), 1'b1);
        // Short request pulse aborts during the warning.
        repeat (2) step(1'b1, 1'b0, 16'h3000, 8'h33, 16'h0A00, 8'($urandom), 1'b1);
        repeat (6) step(1'b0, 1'b0, 16'h3001, 8'h33, 16'h0A01, 8'($urandom), 1'b1);
        // Reset in the middle of VIC ownership.
        repeat (20) step(1'b1, 1'b1, 16'h4000, 8'h44, 16'h0B00, 8'($urandom), 1'b1);
        step(1'b1, 1'b1, 16'h4000, 8'h44, 16'h0B00, 8'h77, 1'b0);
        repeat (6) step(1'b0, 1'b0, 16'h4001, 8'h44, 16'h0B01, 8'($urandom), 1'b1);
        // Random traffic with occasional resets.
        rq = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) rq = ~rq;
            step(rq, 1'($urandom), 16'($urandom), 8'($urandom), 16'($urandom),
                 8'($urandom), ($urandom_range(199) != 0));
        end

        repeat (2) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
